// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC and drives the instruction memory.
// It buffers fetched words in a 2-entry FIFO and presents them to decode over
// a valid/ready handshake. Misaligned redirect targets cause a sticky fault.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] MemAddress,
   output logic        MemEnable,
   input  logic [31:0] MemReadData,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   output logic        Fault
);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [1:0]  count, count_nxt;
   logic [31:0] head_pc, head_pc_nxt, head_instr, head_instr_nxt;
   logic [31:0] tail_pc, tail_pc_nxt, tail_instr, tail_instr_nxt;
   logic        push, pop, flush;

   // State, fetch PC and buffer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= BOOT;
         fetch_pc   <= RESET_PC;
         count      <= '0;
         head_pc    <= '0;
         head_instr <= '0;
         tail_pc    <= '0;
         tail_instr <= '0;
      end else begin
         state      <= state_nxt;
         fetch_pc   <= fetch_pc_nxt;
         count      <= count_nxt;
         head_pc    <= head_pc_nxt;
         head_instr <= head_instr_nxt;
         tail_pc    <= tail_pc_nxt;
         tail_instr <= tail_instr_nxt;
      end
   end

   // Next-state, redirect handling and push/pop decisions
   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      count_nxt      = count;
      head_pc_nxt    = head_pc;
      head_instr_nxt = head_instr;
      tail_pc_nxt    = tail_pc;
      tail_instr_nxt = tail_instr;
      push           = 1'b0;
      pop            = 1'b0;
      flush          = 1'b0;

      case (state)
         BOOT: begin
            state_nxt = RUN;
            if (Redirect) begin
               flush = 1'b1;
               if (RedirectPC[1:0] == 2'b00) fetch_pc_nxt = RedirectPC;
               else                          state_nxt    = FAULT;
            end
         end
         RUN: begin
            if (Redirect) begin
               flush = 1'b1;
               if (RedirectPC[1:0] == 2'b00) fetch_pc_nxt = RedirectPC;
               else                          state_nxt    = FAULT;
            end else begin
               pop  = (count != 2'd0) && InstrReady;
               push = (count != 2'd2) || pop;
            end
         end
         FAULT: begin
            state_nxt = FAULT;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase

      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b11: begin
               // Count is unchanged; at count 1 the new word replaces the head,
               // at count 2 the tail moves up and the new word becomes the tail.
               if (count == 2'd1) begin
                  head_pc_nxt    = fetch_pc;
                  head_instr_nxt = MemReadData;
               end else begin
                  head_pc_nxt    = tail_pc;
                  head_instr_nxt = tail_instr;
                  tail_pc_nxt    = fetch_pc;
                  tail_instr_nxt = MemReadData;
               end
            end
            2'b01: begin
               head_pc_nxt    = tail_pc;
               head_instr_nxt = tail_instr;
               count_nxt      = count - 2'd1;
            end
            2'b10: begin
               if (count == 2'd0) begin
                  head_pc_nxt    = fetch_pc;
                  head_instr_nxt = MemReadData;
               end else begin
                  tail_pc_nxt    = fetch_pc;
                  tail_instr_nxt = MemReadData;
               end
               count_nxt = count + 2'd1;
            end
            default: ;
         endcase
      end

      if (push) fetch_pc_nxt = fetch_pc + 32'd4;
   end

   // Registered-source outputs; the instruction view is zeroed when empty
   always_comb begin
      MemAddress = fetch_pc;
      MemEnable  = (state == RUN);
      Fault      = (state == FAULT);
      InstrValid = (count != 2'd0);
      Instr      = InstrValid ? head_instr : '0;
      InstrPC    = InstrValid ? head_pc    : '0;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// traffic, checked against a queue-based model of the fetch behaviour.
module tb_instr_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] MemAddress;
   logic        MemEnable;
   logic [31:0] MemReadData;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        Fault;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   int          m_mode;   // 0 boot, 1 run, 2 fault

   instr_fetch_unit #(.RESET_PC(RPC)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemAddress (MemAddress),
      .MemEnable  (MemEnable),
      .MemReadData(MemReadData),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Instr      (Instr),
      .InstrPC    (InstrPC),
      .Fault      (Fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + (a >> 2);
   endfunction

   assign MemReadData = MemEnable ? mem_word(MemAddress) : 32'h0;

   task automatic model_reset();
      q.delete();
      m_pc   = RPC;
      m_mode = 0;
   endtask

   // Drive one cycle, compare outputs with the model, then advance the model.
   task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
      logic        e_v;
      logic [31:0] e_i, e_p;
      logic        full, popped;
      Redirect   = redir;
      RedirectPC = rpc;
      InstrReady = rdy;
      #1;
      e_v = (q.size() > 0);
      e_i = e_v ? q[0].ins : 32'h0;
      e_p = e_v ? q[0].pc  : 32'h0;
      checks++;
      if (InstrValid !== e_v) begin failures++; $display("FAIL step_valid: got %b expected %b t=%0t", InstrValid, e_v, $time); end
      checks++;
      if (Instr !== e_i) begin failures++; $display("FAIL step_instr: got %h expected %h t=%0t", Instr, e_i, $time); end
      checks++;
      if (InstrPC !== e_p) begin failures++; $display("FAIL step_pc: got %h expected %h t=%0t", InstrPC, e_p, $time); end
      checks++;
      if (MemAddress !== m_pc) begin failures++; $display("FAIL step_addr: got %h expected %h t=%0t", MemAddress, m_pc, $time); end
      checks++;
      if (MemEnable !== (m_mode == 1)) begin failures++; $display("FAIL step_en: got %b expected %b t=%0t", MemEnable, (m_mode == 1), $time); end
      checks++;
      if (Fault !== (m_mode == 2)) begin failures++; $display("FAIL step_fault: got %b expected %b t=%0t", Fault, (m_mode == 2), $time); end
      @(posedge clk);
      if (m_mode != 2) begin
         if (redir) begin
            q.delete();
            if (rpc[1:0] == 2'b00) begin m_pc = rpc; m_mode = 1; end
            else m_mode = 2;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else begin
            full   = (q.size() == 2);
            popped = (q.size() > 0) && rdy;
            if (popped) void'(q.pop_front());
            if (!full || popped) begin
               q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(negedge clk);
      Redirect = 1'b0;
   endtask

   // Asynchronous reset pulse placed between edges; ends on a negedge.
   task automatic do_reset();
      #2 reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (InstrValid !== 1'b0 || Fault !== 1'b0 || MemEnable !== 1'b0) begin
         failures++; $display("FAIL reset_flags: got v=%b f=%b en=%b expected 0 0 0", InstrValid, Fault, MemEnable);
      end
      checks++;
      if (MemAddress !== RPC) begin failures++; $display("FAIL reset_addr: got %h expected %h", MemAddress, RPC); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(1'b0, 32'h0, 1'b1);   // edge 1 leaves BOOT
      checks++;
      if (MemEnable !== 1'b1 || InstrValid !== 1'b0) begin
         failures++; $display("FAIL boot_exit: got en=%b v=%b expected 1 0", MemEnable, InstrValid);
      end
      step(1'b0, 32'h0, 1'b1);   // edge 2 pushes RESET_PC
      checks++;
      if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || Instr !== 32'hA000_0040) begin
         failures++; $display("FAIL first_fetch: got v=%b pc=%h ins=%h expected 1 00000100 a0000040", InstrValid, InstrPC, Instr);
      end
   endtask

   task automatic test_stream();
      for (int unsigned i = 1; i <= 2; i++) begin
         step(1'b0, 32'h0, 1'b1);
         checks++;
         if (InstrPC !== RPC + 4 * i) begin failures++; $display("FAIL stream_pc: got %h expected %h", InstrPC, RPC + 4 * i); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
      checks++;
      if (MemAddress !== 32'h108) begin failures++; $display("FAIL bp_addr_hold: got %h expected 00000108", MemAddress); end
      checks++;
      if (InstrPC !== 32'h100) begin failures++; $display("FAIL bp_head: got %h expected 00000100", InstrPC); end
      for (int unsigned i = 0; i < 3; i++) begin
         checks++;
         if (InstrPC !== 32'h100 + 4 * i) begin failures++; $display("FAIL bp_release: got %h expected %h", InstrPC, 32'h100 + 4 * i); end
         step(1'b0, 32'h0, 1'b1);
      end
   endtask

   task automatic test_redirect();
      step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h0000_0200, 1'b1);
      checks++;
      if (InstrValid !== 1'b0) begin failures++; $display("FAIL redir_bubble: got %b expected 0", InstrValid); end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (InstrPC !== 32'h200 || Instr !== 32'hA000_0080) begin
         failures++; $display("FAIL redir_target: got pc=%h ins=%h expected 00000200 a0000080", InstrPC, Instr);
      end
   endtask

   task automatic test_wrap();
      step(1'b1, 32'hFFFF_FFFC, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (InstrPC !== 32'hFFFF_FFFC || Instr !== 32'hDFFF_FFFF) begin
         failures++; $display("FAIL wrap_last: got pc=%h ins=%h expected fffffffc dfffffff", InstrPC, Instr);
      end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (InstrPC !== 32'h0 || Instr !== 32'hA000_0000 || Fault !== 1'b0) begin
         failures++; $display("FAIL wrap_zero: got pc=%h ins=%h f=%b expected 00000000 a0000000 0", InstrPC, Instr, Fault);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] held;
      held = MemAddress;
      step(1'b1, 32'h0000_0202, 1'b1);
      checks++;
      if (Fault !== 1'b1 || InstrValid !== 1'b0 || MemEnable !== 1'b0) begin
         failures++; $display("FAIL mis_fault: got f=%b v=%b en=%b expected 1 0 0", Fault, InstrValid, MemEnable);
      end
      checks++;
      if (MemAddress !== held) begin failures++; $display("FAIL mis_pc_hold: got %h expected %h", MemAddress, held); end
      step(1'b1, 32'h0000_0300, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (Fault !== 1'b1 || MemAddress !== held) begin
         failures++; $display("FAIL mis_sticky: got f=%b addr=%h expected 1 %h", Fault, MemAddress, held);
      end
      do_reset();
      checks++;
      if (Fault !== 1'b0) begin failures++; $display("FAIL mis_clear: got %b expected 0", Fault); end
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_async_reset();
      for (int unsigned i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (InstrValid !== 1'b0 || Instr !== 32'h0 || InstrPC !== 32'h0) begin
         failures++; $display("FAIL async_instr: got v=%b ins=%h pc=%h expected 0 0 0", InstrValid, Instr, InstrPC);
      end
      checks++;
      if (Fault !== 1'b0 || MemEnable !== 1'b0 || MemAddress !== RPC) begin
         failures++; $display("FAIL async_mem: got f=%b en=%b addr=%h expected 0 0 %h", Fault, MemEnable, MemAddress, RPC);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (InstrPC !== RPC || InstrValid !== 1'b1) begin
         failures++; $display("FAIL async_restart: got v=%b pc=%h expected 1 %h", InstrValid, InstrPC, RPC);
      end
      step(1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_random();
      logic        r;
      logic [31:0] t;
      for (int unsigned i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 15) == 0);
         t = $urandom();
         if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
         step(r, t, 1'($urandom_range(0, 1)));
         if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      reset      = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      InstrReady = 1'b0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_misaligned();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
